video_bank_ctrl: RTL

// - Double-buffered (ping-pong) 1bpp frame store directly upstream of the VGA timing stage.
// - Writer side accepts packed pixel words from the frame loader into one bank while the other bank is displayed.
// - Reader side supplies pixel_color on every ACTIVE cycle and drives read_bank1/read_bank2, which gate the screen position counter.
// - Banks swap only at frame boundaries; if no new frame is ready, the current frame repeats.

---
 rtl/video_bank_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/video_bank_ctrl.sv
// ============================================================================
// Module      : video_bank_ctrl
// Description : Ping-pong 1bpp frame store feeding the VGA timing stage.
//               Optional repeat statistics enabled by defining VBANK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_bank_ctrl #(
    parameter int H_PIX  = 800,
    parameter int V_PIX  = 600,
    parameter int WORD_W = 16
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              ACTIVE,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              pixel_color,
    output logic              read_bank1,
    output logic              read_bank2
`ifdef VBANK_STATS_EN
    ,
    output logic [15:0]       repeat_cnt
`endif
);

    localparam int c_FRAME_PIXELS = H_PIX * V_PIX;
    localparam int c_FRAME_WORDS  = c_FRAME_PIXELS / WORD_W;
    localparam int c_WA_W         = $clog2(c_FRAME_WORDS);
    localparam int c_MA_W         = $clog2(2 * c_FRAME_WORDS);
    localparam int c_PC_W         = $clog2(c_FRAME_PIXELS);
    localparam int c_BI_W         = $clog2(WORD_W);

    localparam logic [c_WA_W-1:0] c_WA_LAST    = c_WA_W'(c_FRAME_WORDS - 1);
    localparam logic [c_PC_W-1:0] c_PC_LAST    = c_PC_W'(c_FRAME_PIXELS - 1);
    localparam logic [c_BI_W-1:0] c_BI_LAST    = c_BI_W'(WORD_W - 1);
    localparam logic [c_MA_W-1:0] c_BANK1_BASE = c_MA_W'(c_FRAME_WORDS);

    localparam logic [1:0] c_BK_EMPTY   = 2'd0;
    localparam logic [1:0] c_BK_FILLING = 2'd1;
    localparam logic [1:0] c_BK_FULL    = 2'd2;
    localparam logic [1:0] c_BK_DISPLAY = 2'd3;

    localparam logic [1:0] c_RD_IDLE   = 2'd0;
    localparam logic [1:0] c_RD_PRIME  = 2'd1;
    localparam logic [1:0] c_RD_STREAM = 2'd2;

    logic [1:0][1:0]    r_bank_st;
    logic [1:0][1:0]    w_bank_nxt;
    logic [c_WA_W-1:0]  r_wr_addr;
    logic               r_wr_ready;
    logic [1:0]         r_rd_st;
    logic [1:0]         r_prime_cnt;
    logic               r_rd_bank;
    logic [c_WA_W-1:0]  r_rd_addr;
    logic [c_PC_W-1:0]  r_pix_cnt;
    logic [c_BI_W-1:0]  r_bit_idx;
    logic [WORD_W-1:0]  r_cur_word;
    logic [WORD_W-1:0]  r_nxt_word;
    logic [WORD_W-1:0]  r_rd_data;
    logic               r_load_nxt;
    logic               r_read_bank1;
    logic               r_read_bank2;
    logic [WORD_W-1:0]  r_mem [2*c_FRAME_WORDS];

    logic               w_fill_any;
    logic               w_tgt;
    logic               w_tgt_ok;
    logic               w_wr_fire;
    logic               w_wr_last;
    logic               w_wr_ready_nxt;
    logic               w_stream_act;
    logic               w_word_end;
    logic               w_frame_end;
    logic               w_other_full;
    logic               w_swap;
    logic               w_idle_take;
    logic               w_take_bank;
    logic               w_rd_en;
    logic [c_MA_W-1:0]  w_wr_idx;
    logic [c_MA_W-1:0]  w_rd_idx;
    logic [c_BI_W-1:0]  w_bit_sel;

    // Writer targets the FILLING bank, else claims the lowest-index EMPTY bank.
    assign w_fill_any = (r_bank_st[0] == c_BK_FILLING) || (r_bank_st[1] == c_BK_FILLING);
    assign w_tgt      = (r_bank_st[0] == c_BK_FILLING) ? 1'b0 :
                        (r_bank_st[1] == c_BK_FILLING) ? 1'b1 :
                        (r_bank_st[0] == c_BK_EMPTY)   ? 1'b0 : 1'b1;
    assign w_tgt_ok   = w_fill_any || (r_bank_st[0] == c_BK_EMPTY) || (r_bank_st[1] == c_BK_EMPTY);
    assign w_wr_fire  = wr_valid && r_wr_ready && w_tgt_ok;
    assign w_wr_last  = (r_wr_addr == c_WA_LAST);

    assign w_stream_act = (r_rd_st == c_RD_STREAM) && ACTIVE;
    assign w_word_end   = w_stream_act && (r_bit_idx == c_BI_LAST);
    assign w_frame_end  = w_stream_act && (r_pix_cnt == c_PC_LAST);
    assign w_other_full = (r_bank_st[~r_rd_bank] == c_BK_FULL);
    assign w_swap       = w_frame_end && w_other_full;
    assign w_idle_take  = (r_rd_st == c_RD_IDLE) &&
                          ((r_bank_st[0] == c_BK_FULL) || (r_bank_st[1] == c_BK_FULL));
    assign w_take_bank  = (r_bank_st[0] == c_BK_FULL) ? 1'b0 : 1'b1;

    // Writer and reader only ever touch disjoint banks, so both edits apply.
    always_comb begin
        w_bank_nxt = r_bank_st;
        if (w_wr_fire) begin
            w_bank_nxt[w_tgt] = w_wr_last ? c_BK_FULL : c_BK_FILLING;
        end else if (!w_fill_any && w_tgt_ok) begin
            w_bank_nxt[w_tgt] = c_BK_FILLING;
        end
        if (w_idle_take) begin
            w_bank_nxt[w_take_bank] = c_BK_DISPLAY;
        end
        if (w_swap) begin
            w_bank_nxt[r_rd_bank]  = c_BK_EMPTY;
            w_bank_nxt[~r_rd_bank] = c_BK_DISPLAY;
        end
    end

    assign w_wr_ready_nxt = (w_bank_nxt[0] == c_BK_EMPTY) || (w_bank_nxt[0] == c_BK_FILLING) ||
                            (w_bank_nxt[1] == c_BK_EMPTY) || (w_bank_nxt[1] == c_BK_FILLING);

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            r_bank_st  <= {c_BK_EMPTY, c_BK_EMPTY};
            r_wr_addr  <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            r_bank_st  <= w_bank_nxt;
            r_wr_ready <= w_wr_ready_nxt;
            if (w_wr_fire) begin
                r_wr_addr <= w_wr_last ? '0 : r_wr_addr + 1'b1;
            end
        end
    end

    assign w_rd_en  = ((r_rd_st == c_RD_PRIME) && !r_prime_cnt[1]) || (w_word_end && !w_frame_end);
    assign w_wr_idx = (w_tgt ? c_BANK1_BASE : '0) + c_MA_W'(r_wr_addr);
    assign w_rd_idx = (r_rd_bank ? c_BANK1_BASE : '0) + c_MA_W'(r_rd_addr);

    always_ff @(posedge CLK_40) begin
        if (w_wr_fire) begin
            r_mem[w_wr_idx] <= wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

    // PRIME: cycle 0 reads word 0, cycle 1 reads word 1 and latches word 0,
    // cycle 2 latches word 1, cycle 3 hands over to STREAM.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            r_rd_st      <= c_RD_IDLE;
            r_prime_cnt  <= 2'd0;
            r_rd_bank    <= 1'b0;
            r_rd_addr    <= '0;
            r_pix_cnt    <= '0;
            r_bit_idx    <= '0;
            r_cur_word   <= '0;
            r_nxt_word   <= '0;
            r_load_nxt   <= 1'b0;
            r_read_bank1 <= 1'b0;
            r_read_bank2 <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_addr <= (r_rd_addr == c_WA_LAST) ? '0 : r_rd_addr + 1'b1;
            end
            if (r_load_nxt) begin
                r_nxt_word <= r_rd_data;
                r_load_nxt <= 1'b0;
            end
            case (r_rd_st)
                c_RD_IDLE: begin
                    if (w_idle_take) begin
                        r_rd_st      <= c_RD_PRIME;
                        r_prime_cnt  <= 2'd0;
                        r_rd_bank    <= w_take_bank;
                        r_rd_addr    <= '0;
                        r_read_bank1 <= ~w_take_bank;
                        r_read_bank2 <= w_take_bank;
                    end
                end
                c_RD_PRIME: begin
                    r_prime_cnt <= r_prime_cnt + 1'b1;
                    if (r_prime_cnt == 2'd1) begin
                        r_cur_word <= r_rd_data;
                    end
                    if (r_prime_cnt == 2'd2) begin
                        r_nxt_word <= r_rd_data;
                    end
                    if (r_prime_cnt == 2'd3) begin
                        r_rd_st   <= c_RD_STREAM;
                        r_pix_cnt <= '0;
                        r_bit_idx <= '0;
                    end
                end
                c_RD_STREAM: begin
                    if (w_frame_end) begin
                        r_rd_st     <= c_RD_PRIME;
                        r_prime_cnt <= 2'd0;
                        r_rd_addr   <= '0;
                        r_pix_cnt   <= '0;
                        r_bit_idx   <= '0;
                        if (w_swap) begin
                            r_rd_bank    <= ~r_rd_bank;
                            r_read_bank1 <= r_rd_bank;
                            r_read_bank2 <= ~r_rd_bank;
                        end
                    end else if (w_stream_act) begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                        if (w_word_end) begin
                            r_cur_word <= r_nxt_word;
                            r_bit_idx  <= '0;
                            r_load_nxt <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: r_rd_st <= c_RD_IDLE;
            endcase
        end
    end

    assign w_bit_sel   = c_BI_LAST - r_bit_idx;
    assign pixel_color = w_stream_act && r_cur_word[w_bit_sel];
    assign wr_ready    = r_wr_ready;
    assign read_bank1  = r_read_bank1;
    assign read_bank2  = r_read_bank2;

`ifdef VBANK_STATS_EN
    logic [15:0] r_repeat_cnt;

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            r_repeat_cnt <= 16'd0;
        end else if (w_frame_end && !w_other_full && (r_repeat_cnt != 16'hFFFF)) begin
            r_repeat_cnt <= r_repeat_cnt + 16'd1;
        end
    end

    assign repeat_cnt = r_repeat_cnt;
`endif

endmodule

`default_nettype wire
